instr_encoder: RTL and testbench

- Encoder counterpart to the core's opcode decoder. Accepts symbolic instruction requests and builds 32-bit MIPS words for the four supported instructions: ADDI, ADD, LW and SW.
- Writes the words sequentially into instruction memory through a valid/ready write port.
- Used by the boot/program loader and the test harness to fill instruction memory before the core runs.

---
 rtl/instr_encoder.sv | 109 ++++++++++
 tb/tb_instr_encoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Builds 32-bit MIPS words (ADDI/ADD/LW/SW) from symbolic requests and streams
// them into instruction memory over a valid/ready write port, one word per cycle.
module instr_encoder #(
  parameter int                ADDR_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic [1:0]        fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds its payload stable until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       enc_word;
  logic              accept, complete, room;

  always_comb begin
    enc_word = '0;
    unique case (req_kind)
      2'd0: enc_word = {6'b001000, rs, rt, imm};
      2'd1: enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      2'd2: enc_word = {6'b100011, rs, rt, imm};
      2'd3: enc_word = {6'b101011, rs, rt, imm};
      default: enc_word = '0;
    endcase
  end

  // room: the word now completing is not the last one DEPTH allows
  assign room      = (count + CNT_ONE) < DEPTH_C;
  assign complete  = (state == HOLD) && mem_ready;
  assign req_ready = !rst && ((state == IDLE) || (complete && room));
  assign accept    = req_valid && req_ready;

  assign mem_we    = (state == HOLD);
  assign full      = (state == FULL);
  assign mem_addr  = wr_ptr;
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_next = HOLD;
        HOLD: begin
          if (complete) begin
            if (!room)        state_next = FULL;
            else if (!accept) state_next = IDLE;
          end
        end
        FULL:    state_next = FULL;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Clear outranks completion, so a mem_ready seen on the clear cycle is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= BASE;
      count     <= '0;
      mem_wdata <= '0;
    end else if (clear) begin
      wr_ptr <= BASE;
      count  <= '0;
    end else begin
      if (complete) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        count  <= count + CNT_ONE;
      end
      if (accept) mem_wdata <= enc_word;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, stall, full, clear and async reset,
// with DEPTH=4 and BASE=0.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = 2'd0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;
  logic        full;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE(8'd0)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .full(full), .fsm_state(fsm_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] k, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] i);
    req_kind = k; rs = s; rt = t; rd = d; imm = i;
    req_valid = 1'b1;
  endtask

  task automatic do_clear();
    req_valid = 1'b0; mem_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    #2;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b exp 0", mem_we); end
    n_checks++; if (mem_addr !== 8'd0) begin n_fail++; $display("FAIL rst_addr: got %0d exp 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %h exp 0", mem_wdata); end
    n_checks++; if (count !== 9'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", count); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b exp 0", full); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b exp 0", req_ready); end
    n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", fsm_state); end
    req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_encode();
    mem_ready = 1'b1;
    set_req(2'd0, 5'd1, 5'd2, 5'd0, 16'd5);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL enc_ready_idle: got %b exp 1", req_ready); end
    tick();
    set_req(2'd1, 5'd1, 5'd2, 5'd3, 16'hBEEF);
    n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h20220005 || mem_addr !== 8'd0) begin n_fail++; $display("FAIL enc_addi: got we=%b %h @%0d exp 1 20220005 @0", mem_we, mem_wdata, mem_addr); end
    tick();
    set_req(2'd2, 5'd0, 5'd4, 5'd9, 16'd8);
    n_checks++; if (mem_wdata !== 32'h00221820 || mem_addr !== 8'd1 || count !== 9'd1) begin n_fail++; $display("FAIL enc_add: got %h @%0d cnt=%0d exp 00221820 @1 cnt=1", mem_wdata, mem_addr, count); end
    tick();
    set_req(2'd3, 5'd0, 5'd4, 5'd0, 16'hFFFC);
    n_checks++; if (mem_wdata !== 32'h8C040008 || mem_addr !== 8'd2 || count !== 9'd2) begin n_fail++; $display("FAIL enc_lw: got %h @%0d cnt=%0d exp 8c040008 @2 cnt=2", mem_wdata, mem_addr, count); end
    tick();
    req_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hAC04FFFC || mem_addr !== 8'd3 || count !== 9'd3) begin n_fail++; $display("FAIL enc_sw: got we=%b %h @%0d cnt=%0d exp 1 ac04fffc @3 cnt=3", mem_we, mem_wdata, mem_addr, count); end
    tick();
    n_checks++; if (count !== 9'd4 || full !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL enc_done: got cnt=%0d full=%b we=%b exp 4 1 0", count, full, mem_we); end
    do_clear();
    n_checks++; if (count !== 9'd0 || full !== 1'b0 || mem_addr !== 8'd0 || fsm_state !== 2'd0) begin n_fail++; $display("FAIL clr_after_full: got cnt=%0d full=%b @%0d st=%0d exp 0 0 @0 0", count, full, mem_addr, fsm_state); end
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b0;
    set_req(2'd0, 5'd1, 5'd2, 5'd31, 16'd5);
    tick();
    set_req(2'd1, 5'd1, 5'd2, 5'd3, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h20220005 || mem_addr !== 8'd0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d: got we=%b %h @%0d rdy=%b exp 1 20220005 @0 0", i, mem_we, mem_wdata, mem_addr, req_ready); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready: got %b exp 1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h00221820 || mem_addr !== 8'd1 || count !== 9'd1) begin n_fail++; $display("FAIL bp_second: got we=%b %h @%0d cnt=%0d exp 1 00221820 @1 1", mem_we, mem_wdata, mem_addr, count); end
    tick();
    n_checks++; if (mem_we !== 1'b0 || count !== 9'd2 || fsm_state !== 2'd0) begin n_fail++; $display("FAIL bp_idle: got we=%b cnt=%0d st=%0d exp 0 2 0", mem_we, count, fsm_state); end
    do_clear();
  endtask

  task automatic test_full();
    logic [31:0] exp_w;
    mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_req(2'd2, 5'd0, 5'd4, 5'd0, 16'(c));
      req_valid = (c < 6);
      #1;
      n_checks++; if (req_ready !== (c < 4)) begin n_fail++; $display("FAIL full_ready%0d: got %b exp %b", c, req_ready, (c < 4)); end
      tick();
      if (c < 4) begin
        exp_w = {6'b100011, 5'd0, 5'd4, 16'(c)};
        n_checks++; if (mem_we !== 1'b1 || mem_wdata !== exp_w || mem_addr !== 8'(c) || count !== 9'(c)) begin n_fail++; $display("FAIL full_wr%0d: got we=%b %h @%0d cnt=%0d exp 1 %h @%0d %0d", c, mem_we, mem_wdata, mem_addr, count, exp_w, c, c); end
      end else begin
        n_checks++; if (mem_we !== 1'b0 || full !== 1'b1 || count !== 9'd4) begin n_fail++; $display("FAIL full_hold%0d: got we=%b full=%b cnt=%0d exp 0 1 4", c, mem_we, full, count); end
      end
    end
    do_clear();
  endtask

  task automatic test_clear_pending();
    mem_ready = 1'b0;
    set_req(2'd0, 5'd1, 5'd2, 5'd0, 16'd5);
    tick();
    req_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL clr_pend_we: got %b exp 1", mem_we); end
    clear = 1'b1; mem_ready = 1'b1;
    tick();
    clear = 1'b0; mem_ready = 1'b0;
    n_checks++; if (mem_we !== 1'b0 || count !== 9'd0 || mem_addr !== 8'd0) begin n_fail++; $display("FAIL clr_pend: got we=%b cnt=%0d @%0d exp 0 0 @0", mem_we, count, mem_addr); end
    mem_ready = 1'b1;
    set_req(2'd1, 5'd1, 5'd2, 5'd3, 16'd0);
    tick();
    req_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h00221820 || mem_addr !== 8'd0) begin n_fail++; $display("FAIL clr_next: got we=%b %h @%0d exp 1 00221820 @0", mem_we, mem_wdata, mem_addr); end
    tick();
    n_checks++; if (count !== 9'd1) begin n_fail++; $display("FAIL clr_next_cnt: got %0d exp 1", count); end
    do_clear();
  endtask

  task automatic test_async_reset();
    mem_ready = 1'b1;
    set_req(2'd1, 5'd1, 5'd2, 5'd3, 16'd0);
    tick();
    set_req(2'd0, 5'd1, 5'd2, 5'd0, 16'd5);
    tick();
    req_valid = 1'b0; mem_ready = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || count !== 9'd1 || mem_addr !== 8'd1) begin n_fail++; $display("FAIL ar_pre: got we=%b cnt=%0d @%0d exp 1 1 @1", mem_we, count, mem_addr); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0 || full !== 1'b0 || count !== 9'd0 || mem_addr !== 8'd0) begin n_fail++; $display("FAIL ar_async: got we=%b full=%b cnt=%0d @%0d exp 0 0 0 @0", mem_we, full, count, mem_addr); end
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    set_req(2'd0, 5'd7, 5'd8, 5'd0, 16'h1234);
    tick();
    req_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h20E81234 || mem_addr !== 8'd0) begin n_fail++; $display("FAIL ar_first: got we=%b %h @%0d exp 1 20e81234 @0", mem_we, mem_wdata, mem_addr); end
    tick();
    n_checks++; if (count !== 9'd1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL ar_cnt: got cnt=%0d we=%b exp 1 0", count, mem_we); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_backpressure();
    test_full();
    test_clear_pending();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
